// File: rtl/control_fsm.sv
// Multi-cycle processor control unit: Moore FSM sequencing fetch, decode and
// per-class execute states, with every control output held in a register.
module control_fsm (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] Opcode,
    input  logic [2:0] Funct,
    output logic       MemWrite,
    output logic       IRegWrite,
    output logic       RegWrite,
    output logic       PCWrite,
    output logic       PCWriteBeq,
    output logic       PCWriteBne,
    output logic       ALUSrcA,
    output logic [1:0] ALUSRcB,
    output logic [2:0] ALUOp,
    output logic [1:0] IorD,
    output logic [1:0] MemWriteData,
    output logic [1:0] WriteAddr,
    output logic [1:0] WriteData,
    output logic [2:0] PCData,
    output logic       SignExt,
    output logic       Halted
);

    typedef enum logic [3:0] {
        S_RST, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADDR,
        S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_HALT
    } state_t;

    typedef struct packed {
        logic       mem_write;
        logic       ireg_write;
        logic       reg_write;
        logic       pc_write;
        logic       pc_write_beq;
        logic       pc_write_bne;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] iord;
        logic [1:0] mem_write_data;
        logic [1:0] write_addr;
        logic [1:0] write_data;
        logic [2:0] pc_data;
        logic       sign_ext;
        logic       halted;
    } outs_t;

    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_ANDI = 4'b0010;
    localparam logic [3:0] OP_ORI  = 4'b0011;
    localparam logic [3:0] OP_LW   = 4'b0100;
    localparam logic [3:0] OP_SW   = 4'b0101;
    localparam logic [3:0] OP_BEQ  = 4'b0110;
    localparam logic [3:0] OP_BNE  = 4'b0111;
    localparam logic [3:0] OP_J    = 4'b1000;
    localparam logic [3:0] OP_JAL  = 4'b1001;
    localparam logic [3:0] OP_JR   = 4'b1010;
    localparam logic [3:0] OP_LUI  = 4'b1011;
    localparam logic [3:0] OP_HALT = 4'b1111;

    state_t state_q, state_d;
    outs_t  out_q, out_d;

    // Outputs are a function of the state being entered, so registering them
    // alongside the state keeps the block Moore with glitch-free outputs.
    function automatic outs_t decode_outs(input state_t st, input logic [3:0] op,
                                          input logic [2:0] fn);
        outs_t o;
        o = '0;
        case (st)
            S_FETCH: begin
                o.ireg_write = 1'b1;
                o.pc_write   = 1'b1;
                o.alu_src_b  = 2'b01;
            end
            S_DECODE: begin
                o.alu_src_b = 2'b11;
                o.sign_ext  = 1'b1;
            end
            S_EXEC_R: begin
                o.alu_src_a = 1'b1;
                o.alu_op    = fn;
            end
            S_EXEC_I: begin
                o.alu_src_a = 1'b1;
                o.alu_src_b = 2'b10;
                case (op)
                    OP_ANDI: o.alu_op = 3'b010;
                    OP_ORI:  o.alu_op = 3'b011;
                    default: o.alu_op = 3'b000;
                endcase
                o.sign_ext = (op == OP_ADDI);
            end
            S_ALU_WB: begin
                o.reg_write = 1'b1;
                if (op == OP_R)
                    o.write_addr = 2'b01;
                if (op == OP_LUI)
                    o.write_data = 2'b11;
            end
            S_MEM_ADDR: begin
                o.alu_src_a = 1'b1;
                o.alu_src_b = 2'b10;
                o.sign_ext  = 1'b1;
            end
            S_MEM_RD: o.iord = 2'b01;
            S_MEM_WB: begin
                o.reg_write  = 1'b1;
                o.write_data = 2'b01;
            end
            S_MEM_WR: begin
                o.iord      = 2'b01;
                o.mem_write = 1'b1;
            end
            S_BRANCH: begin
                o.alu_src_a    = 1'b1;
                o.alu_op       = 3'b001;
                o.pc_data      = 3'b001;
                o.pc_write_beq = (op == OP_BEQ);
                o.pc_write_bne = (op == OP_BNE);
            end
            S_JUMP: begin
                o.pc_write = 1'b1;
                case (op)
                    OP_JAL: begin
                        o.pc_data    = 3'b010;
                        o.reg_write  = 1'b1;
                        o.write_addr = 2'b10;
                        o.write_data = 2'b10;
                    end
                    OP_JR:   o.pc_data = 3'b011;
                    default: o.pc_data = 3'b010;
                endcase
            end
            S_HALT:  o.halted = 1'b1;
            default: o = '0;
        endcase
        return o;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:    state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_R:                     state_d = S_EXEC_R;
                    OP_ADDI, OP_ANDI, OP_ORI: state_d = S_EXEC_I;
                    OP_LW, OP_SW:             state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:           state_d = S_BRANCH;
                    OP_J, OP_JAL, OP_JR:      state_d = S_JUMP;
                    OP_LUI:                   state_d = S_ALU_WB;
                    OP_HALT:                  state_d = S_HALT;
                    default:                  state_d = S_FETCH;
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
            S_MEM_ADDR: state_d = (Opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = S_MEM_WB;
            S_ALU_WB, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP: state_d = S_FETCH;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_RST;
        endcase
        out_d = decode_outs(state_d, Opcode, Funct);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= S_RST;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    assign MemWrite     = out_q.mem_write;
    assign IRegWrite    = out_q.ireg_write;
    assign RegWrite     = out_q.reg_write;
    assign PCWrite      = out_q.pc_write;
    assign PCWriteBeq   = out_q.pc_write_beq;
    assign PCWriteBne   = out_q.pc_write_bne;
    assign ALUSrcA      = out_q.alu_src_a;
    assign ALUSRcB      = out_q.alu_src_b;
    assign ALUOp        = out_q.alu_op;
    assign IorD         = out_q.iord;
    assign MemWriteData = out_q.mem_write_data;
    assign WriteAddr    = out_q.write_addr;
    assign WriteData    = out_q.write_data;
    assign PCData       = out_q.pc_data;
    assign SignExt      = out_q.sign_ext;
    assign Halted       = out_q.halted;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: a table of {opcode, funct, cycle, outputs}
// vectors plus hand-written reset-during-instruction and HALT sequences.
module tb_control_fsm;

    typedef struct packed {
        logic       mw;
        logic       irw;
        logic       rw;
        logic       pcw;
        logic       beq;
        logic       bne;
        logic       srca;
        logic [1:0] srcb;
        logic [2:0] aluop;
        logic [1:0] iord;
        logic [1:0] mwd;
        logic [1:0] waddr;
        logic [1:0] wdata;
        logic [2:0] pcdata;
        logic       sext;
        logic       halt;
    } outs_t;

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  fn;
        int unsigned cyc;
        outs_t       exp;
    } vec_t;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [3:0] Opcode;
    logic [2:0] Funct;
    logic       MemWrite, IRegWrite, RegWrite, PCWrite, PCWriteBeq, PCWriteBne;
    logic       ALUSrcA, SignExt, Halted;
    logic [1:0] ALUSRcB, IorD, MemWriteData, WriteAddr, WriteData;
    logic [2:0] ALUOp, PCData;
    outs_t      act;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    control_fsm dut (
        .CLK(CLK), .RST_N(RST_N), .Opcode(Opcode), .Funct(Funct),
        .MemWrite(MemWrite), .IRegWrite(IRegWrite), .RegWrite(RegWrite),
        .PCWrite(PCWrite), .PCWriteBeq(PCWriteBeq), .PCWriteBne(PCWriteBne),
        .ALUSrcA(ALUSrcA), .ALUSRcB(ALUSRcB), .ALUOp(ALUOp), .IorD(IorD),
        .MemWriteData(MemWriteData), .WriteAddr(WriteAddr), .WriteData(WriteData),
        .PCData(PCData), .SignExt(SignExt), .Halted(Halted)
    );

    assign act = {MemWrite, IRegWrite, RegWrite, PCWrite, PCWriteBeq, PCWriteBne,
                  ALUSrcA, ALUSRcB, ALUOp, IorD, MemWriteData, WriteAddr,
                  WriteData, PCData, SignExt, Halted};

    function automatic outs_t ex(input logic mw, irw, rw, pcw, beq, bne, srca,
                                 input logic [1:0] srcb, input logic [2:0] aluop,
                                 input logic [1:0] iord, mwd, waddr, wdata,
                                 input logic [2:0] pcdata, input logic sext, halt);
        return {mw, irw, rw, pcw, beq, bne, srca, srcb, aluop, iord, mwd, waddr,
                wdata, pcdata, sext, halt};
    endfunction

    task automatic check(input string name, input outs_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Advance one cycle, then sample; the write-enable exclusivity rules are
    // checked on every cycle the bench steps through.
    task automatic tick();
        @(posedge CLK);
        #1;
        n_tests++;
        if ((int'(PCWrite) + int'(PCWriteBeq) + int'(PCWriteBne)) > 1 ||
            (MemWrite && RegWrite)) begin
            n_fail++;
            $display("FAIL excl: got pcw=%b beq=%b bne=%b mw=%b rw=%b, expected at most one PC write and not mw&rw",
                     PCWrite, PCWriteBeq, PCWriteBne, MemWrite, RegWrite);
        end
    endtask

    // Reset for two cycles, release, check RST outputs, then step into FETCH.
    task automatic start_instr(input logic [3:0] op, input logic [2:0] fn);
        Opcode = op;
        Funct  = fn;
        RST_N  = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;
        check("rst_state", '0);
        tick();
    endtask

    outs_t ZERO, FET, DEC;
    vec_t  vecs[$];

    initial begin
        RST_N  = 1'b0;
        Opcode = 4'b0000;
        Funct  = 3'b000;
        ZERO = '0;
        FET  = ex(0,1,0,1,0,0,0,2'b01,3'b000,2'b00,2'b00,2'b00,2'b00,3'b000,0,0);
        DEC  = ex(0,0,0,0,0,0,0,2'b11,3'b000,2'b00,2'b00,2'b00,2'b00,3'b000,1,0);

        vecs.push_back('{4'b0000, 3'b100, 0, FET});
        vecs.push_back('{4'b0000, 3'b100, 1, DEC});
        vecs.push_back('{4'b0000, 3'b100, 2, ex(0,0,0,0,0,0,1,2'b00,3'b100,2'b00,2'b00,2'b00,2'b00,3'b000,0,0)});
        vecs.push_back('{4'b0000, 3'b100, 3, ex(0,0,1,0,0,0,0,2'b00,3'b000,2'b00,2'b00,2'b01,2'b00,3'b000,0,0)});
        vecs.push_back('{4'b0000, 3'b100, 4, FET});
        vecs.push_back('{4'b0000, 3'b111, 2, ex(0,0,0,0,0,0,1,2'b00,3'b111,2'b00,2'b00,2'b00,2'b00,3'b000,0,0)});
        vecs.push_back('{4'b0001, 3'b000, 2, ex(0,0,0,0,0,0,1,2'b10,3'b000,2'b00,2'b00,2'b00,2'b00,3'b000,1,0)});
        vecs.push_back('{4'b0010, 3'b000, 2, ex(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,2'b00,2'b00,2'b00,3'b000,0,0)});
        vecs.push_back('{4'b0011, 3'b000, 2, ex(0,0,0,0,0,0,1,2'b10,3'b011,2'b00,2'b00,2'b00,2'b00,3'b000,0,0)});
        vecs.push_back('{4'b0011, 3'b000, 3, ex(0,0,1,0,0,0,0,2'b00,3'b000,2'b00,2'b00,2'b00,2'b00,3'b000,0,0)});
        vecs.push_back('{4'b0011, 3'b000, 4, FET});
        vecs.push_back('{4'b1011, 3'b000, 2, ex(0,0,1,0,0,0,0,2'b00,3'b000,2'b00,2'b00,2'b00,2'b11,3'b000,0,0)});
        vecs.push_back('{4'b0100, 3'b000, 2, ex(0,0,0,0,0,0,1,2'b10,3'b000,2'b00,2'b00,2'b00,2'b00,3'b000,1,0)});
        vecs.push_back('{4'b0100, 3'b000, 3, ex(0,0,0,0,0,0,0,2'b00,3'b000,2'b01,2'b00,2'b00,2'b00,3'b000,0,0)});
        vecs.push_back('{4'b0100, 3'b000, 4, ex(0,0,1,0,0,0,0,2'b00,3'b000,2'b00,2'b00,2'b00,2'b01,3'b000,0,0)});
        vecs.push_back('{4'b0100, 3'b000, 5, FET});
        vecs.push_back('{4'b0101, 3'b000, 3, ex(1,0,0,0,0,0,0,2'b00,3'b000,2'b01,2'b00,2'b00,2'b00,3'b000,0,0)});
        vecs.push_back('{4'b0101, 3'b000, 4, FET});
        vecs.push_back('{4'b0110, 3'b000, 2, ex(0,0,0,0,1,0,1,2'b00,3'b001,2'b00,2'b00,2'b00,2'b00,3'b001,0,0)});
        vecs.push_back('{4'b0111, 3'b000, 2, ex(0,0,0,0,0,1,1,2'b00,3'b001,2'b00,2'b00,2'b00,2'b00,3'b001,0,0)});
        vecs.push_back('{4'b0111, 3'b000, 3, FET});
        vecs.push_back('{4'b1000, 3'b000, 2, ex(0,0,0,1,0,0,0,2'b00,3'b000,2'b00,2'b00,2'b00,2'b00,3'b010,0,0)});
        vecs.push_back('{4'b1001, 3'b000, 2, ex(0,0,1,1,0,0,0,2'b00,3'b000,2'b00,2'b00,2'b10,2'b10,3'b010,0,0)});
        vecs.push_back('{4'b1010, 3'b000, 2, ex(0,0,0,1,0,0,0,2'b00,3'b000,2'b00,2'b00,2'b00,2'b00,3'b011,0,0)});
        vecs.push_back('{4'b1010, 3'b000, 3, FET});
        vecs.push_back('{4'b1100, 3'b000, 2, FET});
        vecs.push_back('{4'b1110, 3'b000, 2, FET});
        vecs.push_back('{4'b1111, 3'b000, 2, ex(0,0,0,0,0,0,0,2'b00,3'b000,2'b00,2'b00,2'b00,2'b00,3'b000,0,1)});

        foreach (vecs[i]) begin
            start_instr(vecs[i].op, vecs[i].fn);
            for (int unsigned c = 0; c < vecs[i].cyc; c++)
                tick();
            check($sformatf("vec%0d op=%b fn=%b cyc=%0d", i, vecs[i].op,
                            vecs[i].fn, vecs[i].cyc), vecs[i].exp);
        end

        // sw interrupted by reset in MEM_ADDR: no store may ever be issued.
        start_instr(4'b0101, 3'b000);
        tick();
        tick();
        check("sw_mem_addr", ex(0,0,0,0,0,0,1,2'b10,3'b000,2'b00,2'b00,2'b00,2'b00,3'b000,1,0));
        RST_N = 1'b0;
        tick();
        check("sw_reset_edge", ZERO);
        tick();
        check("sw_reset_hold", ZERO);
        RST_N = 1'b1;
        check("sw_reset_release", ZERO);
        tick();
        check("sw_refetch", FET);

        // HALT holds indefinitely and only reset leaves it.
        start_instr(4'b1111, 3'b000);
        tick();
        tick();
        Opcode = 4'b0000;
        for (int k = 0; k < 12; k++) begin
            tick();
            check($sformatf("halt_hold%0d", k),
                  ex(0,0,0,0,0,0,0,2'b00,3'b000,2'b00,2'b00,2'b00,2'b00,3'b000,0,1));
        end
        RST_N = 1'b0;
        tick();
        check("halt_reset", ZERO);
        RST_N = 1'b1;
        tick();
        check("halt_refetch", FET);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
